// File: rtl/alu_bist_ctrl.sv
// Purpose    : BIST sequencer for the combinational ALU (AND/OR/XOR/ADD). Walks every
//              op x A x B vector, checks results against a golden model, and reports errors.
// Latency    : start sampled at edge N -> first compare in cycle N+1 -> done in cycle N+1+4*2^(2*WIDTH).
// Backpressure: none; start is honoured only in IDLE, and abort only in RUN.
// Ports      : clk/rst (async active-high); start/abort control; alu_a/alu_b/alu_op drive the ALU
//              and alu_result is its combinational result; busy/done/pass/err_count give status;
//              fail_valid/fail_a/fail_b/fail_op/fail_result capture the first mismatching vector.
module alu_bist_ctrl #(
    parameter int WIDTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [1:0]       fail_op,
    output logic [WIDTH-1:0] fail_result
);

    localparam int VW = 2 + 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] golden;
    logic            mismatch;
    logic            last_vec;
    logic [VW-1:0]   vec_nxt;

    always_comb begin
        golden = '0;
        case (alu_op)
            2'd0:    golden = alu_a & alu_b;
            2'd1:    golden = alu_a | alu_b;
            2'd2:    golden = alu_a ^ alu_b;
            default: golden = alu_a + alu_b;  // wraps mod 2^WIDTH by truncation
        endcase
    end

    assign mismatch = (alu_result != golden);
    assign last_vec = (alu_op == 2'd3) && (alu_a == ONES) && (alu_b == ONES);

    // The vector is a single counter {op, a, b}: B is the fastest-moving field,
    // so its carry steps A and A's carry steps op.
    assign vec_nxt = {alu_op, alu_a, alu_b} + VW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (last_vec) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_op     <= '0;
            fail_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        alu_a       <= '0;
                        alu_b       <= '0;
                        alu_op      <= '0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        fail_valid  <= 1'b0;
                        fail_a      <= '0;
                        fail_b      <= '0;
                        fail_op     <= '0;
                        fail_result <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // The vector on the bus during the abort cycle is not scored.
                        alu_a  <= '0;
                        alu_b  <= '0;
                        alu_op <= '0;
                        pass   <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (!fail_valid) begin
                                fail_valid  <= 1'b1;
                                fail_a      <= alu_a;
                                fail_b      <= alu_b;
                                fail_op     <= alu_op;
                                fail_result <= alu_result;
                            end
                        end
                        if (last_vec) begin
                            alu_a  <= '0;
                            alu_b  <= '0;
                            alu_op <= '0;
                            // Includes the last vector's own compare so pass is valid during DONE.
                            pass   <= (err_count == '0) && !mismatch;
                        end else begin
                            {alu_op, alu_a, alu_b} <= vec_nxt;
                        end
                    end
                end
                default: begin
                    alu_a  <= '0;
                    alu_b  <= '0;
                    alu_op <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Purpose    : self-checking bench for alu_bist_ctrl with a fault-injectable ALU model.
// Latency    : n/a (bench).
// Backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_alu_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, start2;

    // DUT 1: ERR_W=8, ALU with per-vector xor fault mask
    logic [1:0] alu_a, alu_b, alu_op, alu_result;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count;
    logic [1:0] fail_a, fail_b, fail_op, fail_result;

    // DUT 2: ERR_W=3, ALU drives ~golden on every vector
    logic [1:0] a2, b2, op2, res2;
    logic       busy2, done2, pass2, fv2;
    logic [2:0] err2;
    logic [1:0] fa2, fb2, fop2, fres2;

    logic [1:0] flt [64];

    int total = 0;
    int bad   = 0;

    function automatic logic [1:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op) ^ flt[{alu_op, alu_a, alu_b}];
    assign res2       = ~alu_fn(a2, b2, op2);

    alu_bist_ctrl #(.WIDTH(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
        .fail_op(fail_op), .fail_result(fail_result)
    );

    alu_bist_ctrl #(.WIDTH(2), .ERR_W(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_result(res2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2),
        .fail_op(fop2), .fail_result(fres2)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer ALU semantics over the full vector space in walk order.
    function automatic int ref_op(input int op, input int a, input int b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return (a + b) % 4;
        endcase
    endfunction

    int exp_err, exp_fv, exp_fa, exp_fb, exp_fop, exp_fres;

    task automatic model(input int sat);
        exp_err = 0; exp_fv = 0; exp_fa = 0; exp_fb = 0; exp_fop = 0; exp_fres = 0;
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    int g;
                    int r;
                    g = ref_op(op, a, b);
                    r = g ^ int'(flt[op * 16 + a * 4 + b]);
                    if (r != g) begin
                        if (exp_err < sat) exp_err++;
                        if (exp_fv == 0) begin
                            exp_fv = 1; exp_fa = a; exp_fb = b; exp_fop = op; exp_fres = r;
                        end
                    end
                end
            end
        end
    endtask

    int nbusy, ndone, done_at, order_bad, snap;

    // Called at the negedge of the first RUN cycle. Tracks the vector walk and
    // returns at the first IDLE cycle after done (or after the cycle budget).
    task automatic monitor(input bit mid_start, input int abort_at);
        int idx;
        idx = 0; nbusy = 0; ndone = 0; done_at = -1; order_bad = 0; snap = -1;
        for (int c = 0; c < 140; c++) begin
            start = 1'b0;
            abort = 1'b0;
            if (abort_at > 0 && nbusy == abort_at && snap < 0)
                snap = int'({busy, done, alu_a, alu_b, alu_op});
            if (busy) begin
                if ({alu_op, alu_a, alu_b} != 6'(idx)) order_bad++;
                idx++;
                nbusy++;
                if (mid_start && (nbusy == 5 || nbusy == 40)) start = 1'b1;
                if (nbusy == abort_at) abort = 1'b1;
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
                if (mid_start) start = 1'b1;
            end else if (ndone > 0) begin
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_end(input string tag);
        model(255);
        check({tag, "_busy_cycles"}, nbusy, 64);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_done_latency"}, done_at, 64);
        check({tag, "_order_bad"}, order_bad, 0);
        check({tag, "_err_count"}, int'(err_count), exp_err);
        check({tag, "_fail_valid"}, int'(fail_valid), exp_fv);
        check({tag, "_fail_a"}, int'(fail_a), exp_fa);
        check({tag, "_fail_b"}, int'(fail_b), exp_fb);
        check({tag, "_fail_op"}, int'(fail_op), exp_fop);
        check({tag, "_fail_result"}, int'(fail_result), exp_fres);
        check({tag, "_pass"}, int'(pass), int'(exp_err == 0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, int'({busy, done, pass, fail_valid, alu_a, alu_b, alu_op}), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_fail"}, int'({fail_a, fail_b, fail_op, fail_result}), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 64; i++) flt[i] = 2'd0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // 1: fault-free run
        pulse_start();
        monitor(1'b0, 0);
        check_end("golden");
        check("golden_pass", int'(pass), 1);

        // 2: AND result bit0 stuck at 0
        for (int i = 0; i < 16; i++) flt[i] = alu_fn(2'(i >> 2), 2'(i), 2'd0) & 2'd1;
        pulse_start();
        monitor(1'b0, 0);
        check_end("stuck");
        check("stuck_err4", int'(err_count), 4);
        check("stuck_first", int'({fail_a, fail_b, fail_op, fail_result}), 8'b01_01_00_00);

        // 3: abort in the 10th RUN cycle, then abort-in-IDLE and start+abort
        for (int i = 0; i < 64; i++) flt[i] = 2'd0;
        pulse_start();
        monitor(1'b0, 10);
        check("abort_busy_cycles", nbusy, 10);
        check("abort_next_state", snap, 0);
        check("abort_no_done", ndone, 0);
        check("abort_pass", int'(pass), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ignored", int'(busy), 0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_wins", int'(busy), 1);
        monitor(1'b0, 0);
        check_end("after_abort");

        // 5: restart pulses during RUN and DONE are ignored; next-IDLE start clears errors
        for (int i = 0; i < 16; i++) flt[i] = alu_fn(2'(i >> 2), 2'(i), 2'd0) & 2'd1;
        pulse_start();
        monitor(1'b1, 0);
        check_end("restart");
        for (int i = 0; i < 64; i++) flt[i] = 2'd0;
        pulse_start();
        check("restart_cleared", int'({busy, pass, fail_valid}), 3'b100);
        check("restart_err_cleared", int'(err_count), 0);
        monitor(1'b0, 0);
        check_end("restart2");

        // randomized fault masks
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 64; i++)
                flt[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            pulse_start();
            monitor(1'b0, 0);
            check_end($sformatf("rand%0d", t));
        end

        // 6: asynchronous reset mid-run
        for (int i = 0; i < 64; i++) flt[i] = 2'($urandom_range(1, 3));
        pulse_start();
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) flt[i] = 2'd0;
        @(negedge clk);
        check("rst_no_done", int'({busy, done}), 0);
        pulse_start();
        monitor(1'b0, 0);
        check_end("after_rst");

        // 4: ERR_W=3 instance against an inverting ALU
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 100 && seen == 0; c++) begin
                if (done2) seen = 1;
                else @(negedge clk);
            end
            check("sat_done_seen", seen, 1);
        end
        @(negedge clk);
        check("sat_err", int'(err2), 7);
        check("sat_fail_valid", int'(fv2), 1);
        check("sat_first", int'({fa2, fb2, fop2, fres2}), 8'b00_00_00_11);
        check("sat_pass", int'(pass2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
